// File: rtl/stall_ctrl_if.sv
// Handshake bundle between the pipeline stages and the stall/flush controller.
// The pipeline (master) raises requests and exceptions; the controller (slave) answers.
interface stall_ctrl_if;
  logic        stallreq_id;
  logic        stallreq_ex;
  logic        stallreq_mem;
  logic [31:0] excepttype;
  logic [31:0] cp0_epc;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic [31:0] stall_cnt;
  logic        wdog_err;

  modport master (
    output stallreq_id, stallreq_ex, stallreq_mem, excepttype, cp0_epc,
    input  stall, flush, new_pc, stall_cnt, wdog_err
  );

  modport slave (
    input  stallreq_id, stallreq_ex, stallreq_mem, excepttype, cp0_epc,
    output stall, flush, new_pc, stall_cnt, wdog_err
  );
endinterface

// File: rtl/stall_ctrl.sv
// Pipeline hold/flush controller: prioritises exceptions over stage stall requests,
// counts stalled cycles and raises a sticky watchdog error on an overlong stall.
module stall_ctrl #(
  parameter int unsigned WDOG_LIMIT = 1023,
  parameter logic [31:0] EXC_BASE   = 32'h00000020
) (
  input  logic         clk,
  input  logic         rst,
  stall_ctrl_if.slave  bus
);
  localparam int          RW        = (WDOG_LIMIT < 1) ? 1 : $clog2(WDOG_LIMIT + 1);
  localparam logic [RW-1:0] RUN_MAX = RW'(WDOG_LIMIT);
  localparam logic [31:0] ERET_CODE = 32'h0000000e;

  typedef enum logic [1:0] {RUN, STALL, FLUSH_HOLD} state_t;

  state_t        state_q, state_d;
  logic [31:0]   cnt_q, cnt_d;
  logic [RW-1:0] run_q, run_d;
  logic          wdog_q, wdog_d;

  logic          exc, hold, req_id, req_ex;
  logic [5:0]    stall;
  logic          flush;
  logic [31:0]   new_pc;

  always_comb begin
    exc    = (bus.excepttype != '0);
    // Requests from ID/EX right after a flush belong to squashed instructions.
    hold   = (state_q == FLUSH_HOLD);
    req_id = bus.stallreq_id && !hold;
    req_ex = bus.stallreq_ex && !hold;
    stall  = '0;
    flush  = 1'b0;
    new_pc = '0;
    if (!rst) begin
      if (exc) begin
        flush  = 1'b1;
        new_pc = (bus.excepttype == ERET_CODE) ? bus.cp0_epc : EXC_BASE;
      end else if (bus.stallreq_mem) begin
        stall = 6'b011111;
      end else if (req_ex) begin
        stall = 6'b001111;
      end else if (req_id) begin
        stall = 6'b000111;
      end
    end
  end

  always_comb begin
    state_d = exc ? FLUSH_HOLD : ((stall != '0) ? STALL : RUN);
    cnt_d   = cnt_q;
    if (stall[0] && (cnt_q != 32'hFFFFFFFF)) cnt_d = cnt_q + 32'd1;
    run_d = '0;
    if (stall[0] && !flush) run_d = (run_q == RUN_MAX) ? run_q : run_q + RW'(1);
    wdog_d = wdog_q | (run_d == RUN_MAX);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      cnt_q   <= '0;
      run_q   <= '0;
      wdog_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      run_q   <= run_d;
      wdog_q  <= wdog_d;
    end
  end

  assign bus.stall     = stall;
  assign bus.flush     = flush;
  assign bus.new_pc    = new_pc;
  assign bus.stall_cnt = cnt_q;
  assign bus.wdog_err  = wdog_q;
endmodule
